uart_tx: RTL
============

# uart_tx

UART transmitter that serialises bytes from a small buffering FIFO onto a single line as 8N1 frames: one start bit, eight data bits LSB first, one stop bit. Upstream logic pushes bytes through a valid/ready handshake. The serial output is bit-compatible with the codebase's `receiver` block at the same `CLKS_PER_BIT`. It is the transmit half of the UART pair.

## Interface
- `CLKS_PER_BIT`, 10417, clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, 4, byte FIFO entries; must be a power of 2 and ≥ 2.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_tx_valid`  in  1  upstream byte valid.
- `i_tx_byte`  in  8  byte to transmit; sampled on accept.
- `o_tx_ready`  out  1  FIFO can accept a byte.
- `o_tx_serial`  out  1  serial line; idle high; registered.
- `o_tx_active`  out  1  high while a frame is on the line (START, DATA or STOP).
- `o_tx_done`  out  1  one-cycle pulse at the end of each stop bit.

## Operation
- Accept: a byte is accepted at a rising edge where `i_tx_valid && o_tx_ready`. `i_tx_byte` is ignored when `i_tx_valid` is low.
- `o_tx_ready` = FIFO count ≠ `FIFO_DEPTH`, derived from the registered count.
- Push and pop in the same cycle leave the count unchanged. A push while full cannot occur.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: line is high. If the FIFO is non-empty, pop the head into the shift register, clear the bit counter and bit index, drive the line low, and go to START.
  - START: hold low for `CLKS_PER_BIT` cycles, then drive `shift[0]` and go to DATA.
  - DATA: each bit is held `CLKS_PER_BIT` cycles. At the end of a bit, shift right and increment the index. After bit 7, drive high and go to STOP.
  - STOP: hold high for `CLKS_PER_BIT` cycles. At the final edge, pulse `o_tx_done`.
    - If the FIFO is non-empty: pop, drive low, go to START directly (no idle cycle).
    - Otherwise: go to IDLE.
- Illegal state encoding: go to IDLE and drive the line high.
- Bit counter width is `$clog2(CLKS_PER_BIT)`. The counter runs 0..`CLKS_PER_BIT`-1 and resets to 0 at each bit boundary. The bit index is 3 bits.
- Reset values: `o_tx_serial`=1, `o_tx_active`=0, `o_tx_done`=0, state=IDLE, counters=0, FIFO empty. `o_tx_ready`=1 once reset is released.
- Reset mid-frame: the line returns high asynchronously and the frame is truncated. No `o_tx_done` pulse is produced, and buffered bytes are discarded.

## Timing
- Latency: for a byte accepted at edge E0 with the FSM idle, `o_tx_serial` goes low at E1 (one cycle).
- Each start, data and stop bit lasts exactly `CLKS_PER_BIT` cycles. A frame lasts 10·`CLKS_PER_BIT` cycles.
- `o_tx_done` is high for the single cycle following the last stop-bit edge. `o_tx_active` falls at that same edge only if no next byte is pending.
- Back-to-back frames have zero gap between the stop bit and the next start bit.
- `o_tx_ready` rises one cycle after the pop that un-fills the FIFO.

## Structure
- Shared package `uart_pkg` contains:
  - the 2-bit state typedef (IDLE=0, START=1, DATA=2, STOP=3), shared with `receiver`;
  - `UART_DATA_BITS`=8;
  - the idle line level constant = 1.
- Sub-module `uart_tx_fifo`: synchronous FIFO, 8-bit width, `FIFO_DEPTH` entries, async active-low reset. It has push/pop ports, head data and a count output. Full and empty flags are derived from the count.
- The FSM and shift register live in `uart_tx`.

## Test plan
- Single byte: `CLKS_PER_BIT`=16, push 0xA5 into an idle block.
  - Line low at +1 cycle for 16 cycles.
  - Then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high for 16 cycles.
  - `o_tx_done` pulses once, 160 cycles after the start edge.
- Back-to-back: push 0x00, 0xFF, 0x55 consecutively.
  - 480 contiguous frame cycles with no extra high cycle between stop and start.
  - Three `o_tx_done` pulses, 160 cycles apart.
- Backpressure: `FIFO_DEPTH`=4, hold valid with 6 distinct bytes.
  - 5 accepted, then `o_tx_ready` low.
  - 6th accepted one cycle after the first `o_tx_done`.
  - All 6 bytes transmitted in order.
- Reset mid-frame: drop `rst_n` during data bit 3 with two bytes queued.
  - Line high immediately; `o_tx_active`=0; no `o_tx_done`.
  - After release, push 0x3C; a single clean frame carrying 0x3C is sent.
- Loopback: `o_tx_serial` → `receiver.i_rx`, `CLKS_PER_BIT`=87, 256 random bytes.
  - Every byte appears on `o_data_byte` in order, with one `o_data_avail` per byte.
- No-valid: toggle `i_tx_byte` with `i_tx_valid`=0 for 1000 cycles.
  - Line stays high; `o_tx_active` and `o_tx_done` stay 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and line constants.
package uart_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_BITS = 8;
    localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO with occupancy count; full/empty are derived by the user.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic          pop,
    output logic [7:0]    rdata,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter draining a small byte FIFO onto a registered serial line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready,
    output logic       o_tx_serial,
    output logic       o_tx_active,
    output logic       o_tx_done
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

    uart_state_e      state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       idx, idx_d;
    logic [7:0]       shift, shift_d, head;
    logic [CW-1:0]    count;
    logic             serial_d, done_d, push, pop, empty, last;

    assign o_tx_ready  = count != CW'(FIFO_DEPTH);
    assign push        = i_tx_valid && o_tx_ready;
    assign empty       = count == '0;
    assign last        = cnt == LAST_CNT;
    assign o_tx_active = state != IDLE;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (i_tx_byte),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            o_tx_serial <= IDLE_LEVEL;
            o_tx_done   <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            idx         <= idx_d;
            shift       <= shift_d;
            o_tx_serial <= serial_d;
            o_tx_done   <= done_d;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        idx_d    = idx;
        shift_d  = shift;
        serial_d = o_tx_serial;
        done_d   = 1'b0;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                serial_d = IDLE_LEVEL;
                if (!empty) begin
                    pop      = 1'b1;
                    shift_d  = head;
                    cnt_d    = '0;
                    idx_d    = '0;
                    serial_d = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                cnt_d = last ? '0 : cnt + 1'b1;
                if (last) begin
                    serial_d = shift[0];
                    state_d  = DATA;
                end
            end
            DATA: begin
                cnt_d = last ? '0 : cnt + 1'b1;
                if (last) begin
                    shift_d  = shift >> 1;
                    idx_d    = idx + 1'b1;
                    serial_d = (idx == LAST_IDX) ? IDLE_LEVEL : shift[1];
                    state_d  = (idx == LAST_IDX) ? STOP : DATA;
                end
            end
            STOP: begin
                cnt_d = last ? '0 : cnt + 1'b1;
                if (last) begin
                    done_d   = 1'b1;
                    pop      = !empty;
                    shift_d  = empty ? shift : head;
                    idx_d    = '0;
                    serial_d = empty ? IDLE_LEVEL : 1'b0;
                    state_d  = empty ? IDLE : START;
                end
            end
            default: begin
                state_d  = IDLE;
                serial_d = IDLE_LEVEL;
            end
        endcase
    end
endmodule
